pll_drp_reconfig: RTL and testbench
===================================

# pll_drp_reconfig

Runtime reconfiguration sequencer for the DR1 PLL wrapper's DRP port. It stores `NUM_PROFILES` register profiles and applies one on request. It holds the PLL in reset, performs read-modify-write on each profile register, releases reset, then waits for a stable lock. It sits between the clocking control logic and the wrapper's `drp_*`, `pllreset` and `lock` pins, replacing fixed-parameter PLL setups with switchable ones.

## Interface
- `NUM_PROFILES`, 4: number of stored profiles (≥1).
- `REGS_PER_PROFILE`, 8: DRP registers per profile (≥1).
- `PROFILE_TABLE`, all zeros: flat vector, `NUM_PROFILES*REGS_PER_PROFILE*24` bits.
  - Entry e = p*REGS_PER_PROFILE + r sits at bits `[24e +: 24]`, laid out as {addr[7:0], mask[7:0], data[7:0]}.
- `RDY_TIMEOUT`, 255: max cycles to wait for `drp_rdy` per access.
- `LOCK_STABLE`, 64: consecutive cycles synchronized lock must stay high.
- `LOCK_TIMEOUT`, 65535: max cycles in lock wait.
- SEL_W = max(1, clog2(NUM_PROFILES)).

Ports:
- `drp_clk`  in  1  sole clock.
- `drp_rst`  in  1  asynchronous, active-high reset.
- `cfg_req`  in  1  start request, level-sampled in IDLE only.
- `cfg_sel`  in  SEL_W  profile index, captured with the accepted request.
- `cfg_busy`  out  1  high from acceptance until DONE is left.
- `cfg_done`  out  1  one-cycle completion pulse (success or error).
- `cfg_err`  out  1  sticky error flag; cleared on next accepted request.
- `cfg_err_code`  out  2  00 none, 01 drp_err, 10 rdy timeout, 11 lock timeout.
- `cur_profile`  out  SEL_W  last profile successfully applied.
- `pll_locked`  out  1  synchronized, stable lock; low while busy.
- `pll_reset`  out  1  to wrapper `pllreset`.
- `pll_lock`  in  1  from wrapper `lock`; asynchronous, 2-FF synchronized.
- `drp_sel`, `drp_rd`, `drp_wr`  out  1 each  DRP strobes.
- `drp_addr`, `drp_wdata`  out  8 each.
- `drp_rdy`, `drp_err`  in  1 each.
- `drp_rdata`  in  8.

## Operation
- States: IDLE → ASSERT_RST → RD → RD_WAIT → WR → WR_WAIT → (next reg: RD) → RELEASE → LOCK_WAIT → DONE → IDLE.
- **IDLE**: on `cfg_req`=1, latch `cfg_sel`, clear reg index / err / err_code, go to ASSERT_RST. Requests in any other state are ignored.
- **ASSERT_RST**: `pll_reset`←1, held through all DRP accesses.
- **RD**: one cycle with `drp_sel`=`drp_rd`=1 and `drp_addr`=entry addr.
- **RD_WAIT**:
  - On `drp_rdy`: capture `drp_rdata` as old, go to WR.
  - If `drp_err` is high in the same cycle as `drp_rdy`, take the error path, code 01.
  - If the counter reaches `RDY_TIMEOUT` with no `drp_rdy`, take the error path, code 10.
- **WR**: one cycle with `drp_sel`=`drp_wr`=1, same addr, and `drp_wdata` = (old & ~mask) | (data & mask).
- **WR_WAIT**: same rdy/err/timeout rules as RD_WAIT.
  - On success: if r = REGS_PER_PROFILE-1, go to RELEASE; otherwise r+1 and go to RD.
- **RELEASE**: `pll_reset`←0, clear both counters.
- **LOCK_WAIT**:
  - Stable counter increments while synced lock=1 and resets to 0 when it drops.
  - Reaching `LOCK_STABLE` → DONE, success: `cur_profile`←latched sel.
  - Timeout counter reaching `LOCK_TIMEOUT` → DONE with code 11.
- **Error path**: `pll_reset`←0 → DONE with `cfg_err`=1. `cur_profile` is unchanged.
- **DONE**: `cfg_done`=1 for one cycle → IDLE.
- `pll_locked` = synced lock AND state==IDLE AND last run had no error.

## Timing
- Reset values: all outputs 0. Lock synchronizer and counters are 0; state is IDLE.
- Reset asserted mid-sequence aborts immediately and `pll_reset` drops asynchronously. Partially written registers are not restored.
- Request accepted at edge N: `cfg_busy`=1 and `pll_reset`=1 from N+1; first `drp_rd` pulse at N+2.
- Each access is 1 strobe cycle plus rdy wait. `drp_rdy` is ignored in the strobe cycle itself.
- With rdy returned one cycle after the strobe: each register costs 4 cycles.
- Lock wait: synchronizer adds 2 cycles, then `LOCK_STABLE` cycles of high lock.
- `cfg_busy` drops in the cycle after the `cfg_done` pulse. `cfg_req` held high then starts a new run one cycle later.
- Counters are wide enough for their maximum parameter value and saturate; they never wrap.

## Test plan
- Profile 2, REGS_PER_PROFILE=2, entries {0x10,0xF0,0xA5} and {0x22,0x0F,0x3C}:
  - DRP model returns 0x5A at 0x10 and 0xFF at 0x22, lock rises 10 cycles after release.
  - Required: writes 0xAA to 0x10 and 0xFC to 0x22; `pll_reset` covers all accesses; `cfg_done` with err=0; `cur_profile`=2.
- Lock glitches low once after 30 cycles high, LOCK_STABLE=64 → done only after 64 uninterrupted high cycles.
- `drp_err`=1 with `drp_rdy` on the 2nd read:
  - Required: no write to that address, `pll_reset`→0, code 01, `cur_profile` unchanged.
- DRP model never asserts rdy, RDY_TIMEOUT=255 → code 10 exactly 255 cycles after the read strobe.
- Lock never rises, LOCK_TIMEOUT=1000 → code 11; `pll_locked`=0.
- Boundary cases:
  - `cfg_req` pulsed while busy is ignored.
  - `drp_rst` pulsed during WR_WAIT → all outputs 0 immediately, then a fresh request completes normally.

Source files
------------

// File: rtl/pll_drp_reconfig_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL wrapper (slave).
interface pll_drp_reconfig_if;
  logic       drp_sel;
  logic       drp_rd;
  logic       drp_wr;
  logic [7:0] drp_addr;
  logic [7:0] drp_wdata;
  logic       drp_rdy;
  logic       drp_err;
  logic [7:0] drp_rdata;

  modport master (
    output drp_sel, drp_rd, drp_wr, drp_addr, drp_wdata,
    input  drp_rdy, drp_err, drp_rdata
  );

  modport slave (
    input  drp_sel, drp_rd, drp_wr, drp_addr, drp_wdata,
    output drp_rdy, drp_err, drp_rdata
  );
endinterface

// File: rtl/pll_drp_reconfig.sv
// PLL DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes
// one stored register profile, releases reset and waits for a stable lock.
module pll_drp_reconfig #(
  parameter int unsigned NUM_PROFILES     = 4,
  parameter int unsigned REGS_PER_PROFILE = 8,
  parameter logic [NUM_PROFILES*REGS_PER_PROFILE*24-1:0] PROFILE_TABLE = '0,
  parameter int unsigned RDY_TIMEOUT      = 255,
  parameter int unsigned LOCK_STABLE      = 64,
  parameter int unsigned LOCK_TIMEOUT     = 65535,
  localparam int unsigned SEL_W = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic             drp_clk,
  input  logic             drp_rst,
  input  logic             cfg_req,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [1:0]       cfg_err_code,
  output logic [SEL_W-1:0] cur_profile,
  output logic             pll_locked,
  output logic             pll_reset,
  input  logic             pll_lock,
  pll_drp_reconfig_if.master drp
);

  localparam int unsigned REG_W = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1;
  localparam int unsigned TBL_W = NUM_PROFILES * REGS_PER_PROFILE * 24;
  localparam int unsigned IDX_W = (TBL_W > 1) ? $clog2(TBL_W) : 1;
  localparam int unsigned RDY_W = $clog2(RDY_TIMEOUT + 1) > 0 ? $clog2(RDY_TIMEOUT + 1) : 1;
  localparam int unsigned LST_W = $clog2(LOCK_STABLE + 1) > 0 ? $clog2(LOCK_STABLE + 1) : 1;
  localparam int unsigned LTO_W = $clog2(LOCK_TIMEOUT + 1) > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
    S_RELEASE, S_LOCK_WAIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [RDY_W-1:0]   rdy_cnt_q, rdy_cnt_d;
  logic [LST_W-1:0]   stable_q, stable_d;
  logic [LTO_W-1:0]   tmo_q, tmo_d;
  logic [1:0]         lock_sync_q, lock_sync_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic               locked_q, locked_d;
  logic               pll_reset_q, pll_reset_d;
  logic               drp_sel_q, drp_sel_d;
  logic               drp_rd_q, drp_rd_d;
  logic               drp_wr_q, drp_wr_d;
  logic [7:0]         drp_addr_q, drp_addr_d;
  logic [7:0]         drp_wdata_q, drp_wdata_d;

  logic [23:0] cur_ent, nxt_ent;
  logic        fail;
  logic [1:0]  fail_code;
  logic        rdy_expired;

  // Out-of-range profile/register indices read as an all-zero entry.
  function automatic logic [23:0] entry(input logic [SEL_W-1:0] s, input int unsigned r);
    int unsigned e;
    logic [IDX_W-1:0] base;
    e = 32'(s) * REGS_PER_PROFILE + r;
    if (32'(s) >= NUM_PROFILES || r >= REGS_PER_PROFILE) return '0;
    base = IDX_W'(e * 24);
    return PROFILE_TABLE[base +: 24];
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    reg_d       = reg_q;
    rdy_cnt_d   = rdy_cnt_q;
    stable_d    = stable_q;
    tmo_d       = tmo_q;
    lock_sync_d = {lock_sync_q[0], pll_lock};
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    code_d      = code_q;
    cur_d       = cur_q;
    pll_reset_d = pll_reset_q;
    drp_sel_d   = 1'b0;
    drp_rd_d    = 1'b0;
    drp_wr_d    = 1'b0;
    drp_addr_d  = drp_addr_q;
    drp_wdata_d = drp_wdata_q;
    fail        = 1'b0;
    fail_code   = 2'b00;

    cur_ent     = entry(sel_q, 32'(reg_q));
    nxt_ent     = entry(sel_q, 32'(reg_q) + 1);
    // The strobe cycle counts as the first cycle of an access.
    rdy_expired = (32'(rdy_cnt_q) + 32'd1 >= RDY_TIMEOUT);

    case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          sel_d       = cfg_sel;
          reg_d       = '0;
          err_d       = 1'b0;
          code_d      = 2'b00;
          busy_d      = 1'b1;
          pll_reset_d = 1'b1;
          state_d     = S_ASSERT_RST;
        end
      end
      S_ASSERT_RST: begin
        drp_sel_d  = 1'b1;
        drp_rd_d   = 1'b1;
        drp_addr_d = cur_ent[23:16];
        state_d    = S_RD;
      end
      S_RD: begin
        rdy_cnt_d = RDY_W'(1);
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drp.drp_rdy) begin
          if (drp.drp_err) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else begin
            drp_wdata_d = (drp.drp_rdata & ~cur_ent[15:8]) | (cur_ent[7:0] & cur_ent[15:8]);
            drp_sel_d   = 1'b1;
            drp_wr_d    = 1'b1;
            state_d     = S_WR;
          end
        end else if (rdy_expired) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          rdy_cnt_d = rdy_cnt_q + RDY_W'(1);
        end
      end
      S_WR: begin
        rdy_cnt_d = RDY_W'(1);
        state_d   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drp.drp_rdy) begin
          if (drp.drp_err) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else if (32'(reg_q) == REGS_PER_PROFILE - 1) begin
            pll_reset_d = 1'b0;
            state_d     = S_RELEASE;
          end else begin
            reg_d      = reg_q + REG_W'(1);
            drp_sel_d  = 1'b1;
            drp_rd_d   = 1'b1;
            drp_addr_d = nxt_ent[23:16];
            state_d    = S_RD;
          end
        end else if (rdy_expired) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          rdy_cnt_d = rdy_cnt_q + RDY_W'(1);
        end
      end
      S_RELEASE: begin
        stable_d = '0;
        tmo_d    = '0;
        state_d  = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (lock_sync_q[1] && (32'(stable_q) + 32'd1 >= LOCK_STABLE)) begin
          done_d  = 1'b1;
          cur_d   = sel_q;
          state_d = S_DONE;
        end else begin
          stable_d = lock_sync_q[1] ? stable_q + LST_W'(1) : '0;
          if (32'(tmo_q) + 32'd1 >= LOCK_TIMEOUT) begin
            fail      = 1'b1;
            fail_code = 2'b11;
          end else begin
            tmo_d = tmo_q + LTO_W'(1);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      err_d       = 1'b1;
      code_d      = fail_code;
      pll_reset_d = 1'b0;
      done_d      = 1'b1;
      state_d     = S_DONE;
    end

    locked_d = lock_sync_d[1] && (state_d == S_IDLE) && !err_d;
  end

  always_ff @(posedge drp_clk or posedge drp_rst) begin
    if (drp_rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      reg_q       <= '0;
      rdy_cnt_q   <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      lock_sync_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
      cur_q       <= '0;
      locked_q    <= 1'b0;
      pll_reset_q <= 1'b0;
      drp_sel_q   <= 1'b0;
      drp_rd_q    <= 1'b0;
      drp_wr_q    <= 1'b0;
      drp_addr_q  <= '0;
      drp_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      reg_q       <= reg_d;
      rdy_cnt_q   <= rdy_cnt_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      lock_sync_q <= lock_sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      cur_q       <= cur_d;
      locked_q    <= locked_d;
      pll_reset_q <= pll_reset_d;
      drp_sel_q   <= drp_sel_d;
      drp_rd_q    <= drp_rd_d;
      drp_wr_q    <= drp_wr_d;
      drp_addr_q  <= drp_addr_d;
      drp_wdata_q <= drp_wdata_d;
    end
  end

  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign cfg_err_code  = code_q;
  assign cur_profile   = cur_q;
  assign pll_locked    = locked_q;
  assign pll_reset     = pll_reset_q;
  assign drp.drp_sel   = drp_sel_q;
  assign drp.drp_rd    = drp_rd_q;
  assign drp.drp_wr    = drp_wr_q;
  assign drp.drp_addr  = drp_addr_q;
  assign drp.drp_wdata = drp_wdata_q;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig: DRP slave model, scripted PLL lock, fixed expectations.
module tb_pll_drp_reconfig;

  localparam int unsigned NP = 4;
  localparam int unsigned RP = 2;
  // Entries e7..e0; profile 1 = {30,FF,11},{31,80,80}; profile 2 = {10,F0,A5},{22,0F,3C}.
  localparam logic [NP*RP*24-1:0] TABLE = {24'h000000, 24'h000000, 24'h220F3C, 24'h10F0A5,
                                           24'h318080, 24'h30FF11, 24'h000000, 24'h000000};

  logic       drp_clk = 1'b0;
  logic       drp_rst;
  logic       cfg_req;
  logic [1:0] cfg_sel;
  logic       cfg_busy, cfg_done, cfg_err;
  logic [1:0] cfg_err_code;
  logic [1:0] cur_profile;
  logic       pll_locked, pll_reset, pll_lock;

  pll_drp_reconfig_if dif();

  pll_drp_reconfig #(
    .NUM_PROFILES(NP), .REGS_PER_PROFILE(RP), .PROFILE_TABLE(TABLE),
    .RDY_TIMEOUT(255), .LOCK_STABLE(64), .LOCK_TIMEOUT(1000)
  ) dut (
    .drp_clk(drp_clk), .drp_rst(drp_rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_err_code(cfg_err_code), .cur_profile(cur_profile), .pll_locked(pll_locked),
    .pll_reset(pll_reset), .pll_lock(pll_lock), .drp(dif.master)
  );

  always #5 drp_clk = ~drp_clk;

  // DRP slave model: rdy one cycle after each strobe, optional err / silence.
  logic       never_rdy, log_clr;
  int         err_read_n;
  int         wr_n, rd_n, reset_viol;
  logic [7:0] wr_addr_log [4];
  logic [7:0] wr_data_log [4];

  function automatic logic [7:0] rd_value(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h5A;
      8'h22:   return 8'hFF;
      8'h31:   return 8'h7F;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge drp_clk) begin
    dif.drp_rdy <= 1'b0;
    dif.drp_err <= 1'b0;
    if (log_clr) begin
      wr_n <= 0; rd_n <= 0; reset_viol <= 0;
    end else if (dif.drp_sel) begin
      if (!pll_reset) reset_viol <= reset_viol + 1;
      if (dif.drp_rd) begin
        rd_n <= rd_n + 1;
        if (!never_rdy) begin
          dif.drp_rdy   <= 1'b1;
          dif.drp_rdata <= rd_value(dif.drp_addr);
          if (rd_n + 1 == err_read_n) dif.drp_err <= 1'b1;
        end
      end
      if (dif.drp_wr) begin
        if (wr_n < 4) begin
          wr_addr_log[wr_n] <= dif.drp_addr;
          wr_data_log[wr_n] <= dif.drp_wdata;
        end
        wr_n <= wr_n + 1;
        if (!never_rdy) dif.drp_rdy <= 1'b1;
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  int         t, rel_t, rd_t, done_t, lock_delay, glitch_at;
  logic       prev_reset, done_err, done_rst;
  logic [1:0] done_code, done_cur;

  // One cycle: sample at negedge, script the lock pin relative to reset release.
  task automatic tick();
    int c;
    @(negedge drp_clk);
    t++;
    if (pll_reset) pll_lock = 1'b0;
    if (prev_reset && !pll_reset && cfg_busy && rel_t < 0) rel_t = t;
    prev_reset = pll_reset;
    if (rel_t >= 0 && lock_delay >= 0) begin
      c = t - rel_t;
      if (c == lock_delay) pll_lock = 1'b1;
      if (glitch_at > 0 && c == lock_delay + glitch_at) pll_lock = 1'b0;
      if (glitch_at > 0 && c == lock_delay + glitch_at + 1) pll_lock = 1'b1;
    end
    if (dif.drp_rd && rd_t < 0) rd_t = t;
    if (cfg_done && done_t < 0) begin
      done_t = t; done_err = cfg_err; done_code = cfg_err_code;
      done_cur = cur_profile; done_rst = pll_reset;
    end
  endtask

  task automatic start(input logic [1:0] sel, input int ld, input int gl, input string tag);
    lock_delay = ld; glitch_at = gl;
    rel_t = -1; rd_t = -1; done_t = -1;
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    cfg_sel = sel;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    check({tag, "_busy"}, {31'd0, cfg_busy}, 32'd1);
    check({tag, "_pllrst"}, {31'd0, pll_reset}, 32'd1);
    check({tag, "_err_clr"}, {29'd0, cfg_err, cfg_err_code}, 32'd0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && done_t < 0; i++) tick();
    check({tag, "_done_seen"}, {31'd0, done_t >= 0}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {22'd0, cfg_busy, cfg_done, cfg_err, cfg_err_code, cur_profile,
                          pll_locked, pll_reset}, 32'd0);
    check({tag, "_bus"}, {13'd0, dif.drp_sel, dif.drp_rd, dif.drp_wr, dif.drp_addr,
                          dif.drp_wdata}, 32'd0);
  endtask

  initial begin
    drp_rst = 1'b1; cfg_req = 1'b0; cfg_sel = '0; pll_lock = 1'b0;
    never_rdy = 1'b0; err_read_n = 0; log_clr = 1'b1;
    t = 0; rel_t = -1; rd_t = -1; done_t = -1; lock_delay = -1; glitch_at = 0;
    prev_reset = 1'b0; done_err = 1'b0; done_rst = 1'b0; done_code = '0; done_cur = '0;
    tick(); tick();
    check_all_zero("reset");
    drp_rst = 1'b0;
    tick();

    // Profile 2 success, with a request pulsed while busy
    start(2'd2, 10, 0, "p2");
    tick();
    check("p2_first_rd", {31'd0, dif.drp_rd}, 32'd1);
    check("p2_first_addr", {24'd0, dif.drp_addr}, 32'h10);
    tick(); tick();
    cfg_sel = 2'd3; cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    check("p2_locked_busy", {31'd0, pll_locked}, 32'd0);
    wait_done(400, "p2");
    check("p2_err", {29'd0, done_err, done_code}, 32'd0);
    check("p2_cur", {30'd0, done_cur}, 32'd2);
    check("p2_lock_lat", done_t - rel_t, 32'd76);
    check("p2_wr_n", wr_n, 32'd2);
    check("p2_wr0", {16'd0, wr_addr_log[0], wr_data_log[0]}, 32'h10AA);
    check("p2_wr1", {16'd0, wr_addr_log[1], wr_data_log[1]}, 32'h22FC);
    check("p2_rst_cover", reset_viol, 32'd0);
    tick(); tick(); tick();
    check("p2_idle_busy", {31'd0, cfg_busy}, 32'd0);
    check("p2_locked", {31'd0, pll_locked}, 32'd1);
    check("p2_no_rerun", wr_n, 32'd2);

    // Profile 1 with a one-cycle lock glitch after 30 high cycles
    start(2'd1, 10, 30, "glitch");
    wait_done(400, "glitch");
    check("glitch_err", {31'd0, done_err}, 32'd0);
    check("glitch_cur", {30'd0, done_cur}, 32'd1);
    check("glitch_lat", done_t - rel_t, 32'd107);
    check("glitch_wr0", {16'd0, wr_addr_log[0], wr_data_log[0]}, 32'h3011);
    check("glitch_wr1", {16'd0, wr_addr_log[1], wr_data_log[1]}, 32'h31FF);

    // drp_err with rdy on the second read
    err_read_n = 2;
    start(2'd2, -1, 0, "drperr");
    wait_done(400, "drperr");
    err_read_n = 0;
    check("drperr_code", {29'd0, done_err, done_code}, 32'b101);
    check("drperr_pllrst", {31'd0, done_rst}, 32'd0);
    check("drperr_cur", {30'd0, done_cur}, 32'd1);
    check("drperr_wr_n", wr_n, 32'd1);
    check("drperr_wr0", {24'd0, wr_addr_log[0]}, 32'h10);

    // DRP never answers
    never_rdy = 1'b1;
    start(2'd2, -1, 0, "rdyto");
    wait_done(400, "rdyto");
    never_rdy = 1'b0;
    check("rdyto_code", {29'd0, done_err, done_code}, 32'b110);
    check("rdyto_lat", done_t - rd_t, 32'd255);
    check("rdyto_wr_n", wr_n, 32'd0);
    check("rdyto_pllrst", {31'd0, done_rst}, 32'd0);

    // Lock never rises
    start(2'd1, -1, 0, "lockto");
    wait_done(1200, "lockto");
    check("lockto_code", {29'd0, done_err, done_code}, 32'b111);
    check("lockto_lat", done_t - rel_t, 32'd1001);
    check("lockto_cur", {30'd0, done_cur}, 32'd1);
    pll_lock = 1'b1;
    tick(); tick(); tick();
    check("lockto_locked", {31'd0, pll_locked}, 32'd0);

    // Reset during WR_WAIT, then a fresh run
    start(2'd2, 10, 0, "midrst");
    for (int i = 0; i < 20 && !dif.drp_wr; i++) tick();
    check("midrst_wr_seen", {31'd0, dif.drp_wr}, 32'd1);
    tick();
    drp_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    drp_rst = 1'b0;
    tick();
    start(2'd2, 10, 0, "fresh");
    wait_done(400, "fresh");
    check("fresh_err", {29'd0, done_err, done_code}, 32'd0);
    check("fresh_cur", {30'd0, done_cur}, 32'd2);
    check("fresh_wr1", {16'd0, wr_addr_log[1], wr_data_log[1]}, 32'h22FC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
